alu_result_display: RTL and testbench

Downstream consumer of the 4-bit ALU top level. It captures the 5-bit ALU result each time the toggle unit signals ready and holds the most recent results in a small history buffer. It drives a two-digit, time-multiplexed, active-low seven-segment display showing the selected result as hex: digit 1 is the carry/bit 4, digit 0 is bits 3:0. It sits between the ALU top outputs (Alu_out, Led_rdy) and the board display pins.

---
 rtl/alu_result_display.sv | 132 +++++++++++++
 tb/tb_alu_result_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// Captures the ALU result on each Led_rdy rising edge and shows it as two-digit hex on a muxed 7-seg display (history: ALU_DISP_HISTORY_EN).
// Latency: Result_valid/Hist_idx update at the capture edge, Seg one edge later; each digit is lit for SCAN_DIV cycles.
// Backpressure: none; captures are never stalled and a full history silently overwrites its oldest entry.
module alu_result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Alu_out,
    input  logic       Led_rdy,
    input  logic       Show_prev,
    output logic [6:0] Seg,
    output logic [1:0] An,
    output logic       Result_valid,
    output logic [1:0] Hist_idx
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic          rdy_q;
    logic          prev_q;
    logic          capture;
    logic          step;
    logic [2:0]    count;
    logic [PW-1:0] presc;
    logic          dsel;
    logic          dsel_nxt;
    logic [4:0]    disp;
    logic [3:0]    digit;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign capture      = Led_rdy & ~rdy_q;
    assign step         = Show_prev & ~prev_q;
    assign Result_valid = (count != 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            rdy_q  <= Led_rdy;
            prev_q <= Show_prev;
        end
    end

`ifdef ALU_DISP_HISTORY_EN
    logic [4:0] hist_buf [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] idx_inc;

    assign idx_inc = {1'b0, Hist_idx} + 3'd1;
    // wr_ptr points one past the newest entry; Hist_idx counts back from there
    assign rd_ptr  = wr_ptr - 2'd1 - Hist_idx;
    assign disp    = hist_buf[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) hist_buf[i] <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            Hist_idx <= '0;
        end else if (capture) begin
            hist_buf[wr_ptr] <= Alu_out;
            wr_ptr           <= wr_ptr + 2'd1;
            if (count != 3'd4) count <= count + 3'd1;
            Hist_idx         <= '0;
        end else if (step && (count != 3'd0)) begin
            Hist_idx <= (idx_inc >= count) ? 2'd0 : idx_inc[1:0];
        end
    end
`else
    logic [4:0] result_q;

    assign disp = result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            count    <= '0;
            Hist_idx <= '0;
        end else begin
            if (capture) begin
                result_q <= Alu_out;
                count    <= 3'd1;
            end
            // Only one entry exists, so any capture or step lands on age 0
            if (capture || step) Hist_idx <= 2'd0;
        end
    end
`endif

    // Seg is built from the post-toggle digit select so An and Seg switch together
    assign dsel_nxt = (presc == PRESC_MAX) ? ~dsel : dsel;
    assign digit    = dsel_nxt ? {3'b000, disp[4]} : disp[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            dsel  <= 1'b0;
            An    <= 2'b11;
            Seg   <= 7'h7F;
        end else begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
            dsel  <= dsel_nxt;
            An    <= dsel_nxt ? 2'b01 : 2'b10;
            Seg   <= Result_valid ? hex_seg(digit) : 7'h3F;
        end
    end
endmodule

// File: tb/tb_alu_result_display.sv
// Directed + random bench for alu_result_display, scored against a queue-based history model.
module tb_alu_result_display;
    localparam int SCAN_DIV = 4;
`ifdef ALU_DISP_HISTORY_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] Alu_out = '0;
    logic       Led_rdy = 1'b0;
    logic       Show_prev = 1'b0;
    logic [6:0] Seg;
    logic [1:0] An;
    logic       Result_valid;
    logic [1:0] Hist_idx;

    int checks = 0;
    int failures = 0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: newest result at index 0, hidx_m is the age being displayed
    logic [4:0] hist_m [$];
    int         hidx_m;
    int         k_m;
    bit         rdy_m;
    bit         prev_m;

    alu_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .Alu_out      (Alu_out),
        .Led_rdy      (Led_rdy),
        .Show_prev    (Show_prev),
        .Seg          (Seg),
        .An           (An),
        .Result_valid (Result_valid),
        .Hist_idx     (Hist_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_m.delete();
        hidx_m = 0;
        k_m    = 0;
        rdy_m  = 1'b0;
        prev_m = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_seg"},   {1'b0, Seg},          8'h7F);
        check({tag, "_an"},    {6'b0, An},           8'h03);
        check({tag, "_valid"}, {7'b0, Result_valid}, 8'h00);
        check({tag, "_hidx"},  {6'b0, Hist_idx},     8'h00);
    endtask

    // Called just after a rising edge; drives inputs, advances one edge, scores outputs
    task automatic do_cycle(input logic rdy, input logic sp, input logic [4:0] alu);
        int         dsel;
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        logic [4:0] v;
        bit         cap;
        bit         stp;
        Led_rdy   = rdy;
        Show_prev = sp;
        Alu_out   = alu;
        @(posedge clk);
        k_m++;
        dsel   = (k_m / SCAN_DIV) % 2;
        exp_an = (dsel == 1) ? 2'b01 : 2'b10;
        if (hist_m.size() == 0) begin
            exp_seg = 7'h3F;
        end else begin
            v       = hist_m[hidx_m];
            exp_seg = (dsel == 1) ? font[{3'b000, v[4]}] : font[v[3:0]];
        end
        cap    = rdy && !rdy_m;
        stp    = sp && !prev_m;
        rdy_m  = rdy;
        prev_m = sp;
        if (cap) begin
            hist_m.push_front(alu);
            if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
            hidx_m = 0;
        end else if (stp && hist_m.size() != 0) begin
            hidx_m = (hidx_m + 1) % hist_m.size();
        end
        #1;
        check("seg",   {1'b0, Seg},          {1'b0, exp_seg});
        check("an",    {6'b0, An},           {6'b0, exp_an});
        check("valid", {7'b0, Result_valid}, {7'b0, (hist_m.size() != 0)});
        check("hidx",  {6'b0, Hist_idx},     8'(hidx_m));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 5'($urandom));
    endtask

    initial begin
        model_reset();
        #23;
        check_reset("por");
        release_reset();

        // Blank display, scan alternation before any capture
        idle(2 * SCAN_DIV);

        // Single capture of 1A
        do_cycle(1'b1, 1'b0, 5'h1A);
        idle(9);

        // Held ready: only the first high cycle captures
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 5'(5'h10 + i));
        idle(9);

        // Overfill the history, then step back through it
        for (int i = 1; i <= 5; i++) begin
            do_cycle(1'b1, 1'b0, 5'(i));
            do_cycle(1'b0, 1'b0, 5'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 5'($urandom));
            idle(4);
        end

        // Step and capture on the same edge: capture wins
        do_cycle(1'b0, 1'b1, 5'($urandom));
        do_cycle(1'b0, 1'b0, 5'($urandom));
        do_cycle(1'b1, 1'b1, 5'h17);
        idle(8);

        // Random traffic
        for (int i = 0; i < 300; i++)
            do_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 5'($urandom));

        // Reset mid-scan, then steps with an empty history
        rst = 1'b0;
        #1;
        check_reset("mid");
        repeat (3) @(posedge clk);
        #1;
        check_reset("held");
        Led_rdy   = 1'b0;
        Show_prev = 1'b0;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 5'($urandom));
            do_cycle(1'b0, 1'b0, 5'($urandom));
        end
        do_cycle(1'b1, 1'b0, 5'h0C);
        idle(8);

        // Led_rdy already high when reset releases is captured at the first edge
        rst     = 1'b0;
        Led_rdy = 1'b1;
        #1;
        check_reset("rdyhi");
        release_reset();
        do_cycle(1'b1, 1'b0, 5'h1F);
        do_cycle(1'b1, 1'b0, 5'h03);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
